// File: rtl/psg_bus_sequencer.sv
// -----------------------------------------------------------------------------
// psg_bus_sequencer
//
// Purpose:
//   Sole master of the turbosound PSG bus (bdir/bc1/psg_din, bc2 tied high).
//   It shares the bus between the CPU port decoder (0xFFFD select,
//   0xBFFD data) and a background register-write requester (DMA/player).
//   A DMA operation is an atomic sequence:
//     optional chip select -> register latch -> data write ->
//     optional chip restore -> register restore.
//   The CPU's chip/register selection is shadowed so that the restore puts
//   the PSGs back into the state the CPU believes they are in.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   cpu_sel_wr           1-clk pulse: CPU write to 0xFFFD (select), data on cpu_data
//   cpu_dat_wr           1-clk pulse: CPU write to 0xBFFD (data), data on cpu_data
//   cpu_dat_rd           level: CPU read from 0xFFFD in progress
//   cpu_data[7:0]        CPU write data
//   cpu_wait             stall request while a read waits for the sequencer
//   cpu_overrun          1-clk pulse: a pending CPU write was overwritten
//   dma_req              level: register write request (operands stable until ack)
//   dma_chip             target PSG (1 = first, 0 = second)
//   dma_reg[3:0]         target register
//   dma_data[7:0]        value to write
//   dma_ack              1-clk pulse on the idle clk of the DMA data write
//   bdir, bc1            PSG bus control: 00 idle, 01 read, 10 write, 11 address
//   psg_din[7:0]         PSG bus data
//   busy                 sequencer is not idle
// -----------------------------------------------------------------------------
module psg_bus_sequencer #(
    parameter int STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cpu_sel_wr,
    input  logic       cpu_dat_wr,
    input  logic       cpu_dat_rd,
    input  logic [7:0] cpu_data,
    output logic       cpu_wait,
    output logic       cpu_overrun,
    input  logic       dma_req,
    input  logic       dma_chip,
    input  logic [3:0] dma_reg,
    input  logic [7:0] dma_data,
    output logic       dma_ack,
    output logic       bdir,
    output logic       bc1,
    output logic [7:0] psg_din,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CPU_ADDR,
        S_CPU_DATA,
        S_D_CHIP,
        S_D_REG,
        S_D_DATA,
        S_R_CHIP,
        S_R_REG
    } state_t;

    // Clock index of the idle clk that closes every bus cycle.
    localparam logic [3:0] LAST_CNT = 4'(STROBE_CYCLES);
    // Select codes 0xFE/0xFF choose a chip instead of a register.
    localparam logic [6:0] CHIP_SEL = 7'h7F;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] din_q, din_d;
    logic       sel_pend_q, sel_pend_d;
    logic [7:0] sel_val_q, sel_val_d;
    logic       dat_pend_q, dat_pend_d;
    logic [7:0] dat_val_q, dat_val_d;
    logic       cpu_chip_q, cpu_chip_d;
    logic [7:0] cpu_reg_q, cpu_reg_d;
    logic       hw_chip_q, hw_chip_d;
    logic       overrun_q, overrun_d;

    logic       cycle_end;
    logic       is_addr_cycle;
    logic       rd_pass;
    logic [7:0] sel_v;
    logic [7:0] dat_v;

    assign cycle_end     = (state_q != S_IDLE) && (cnt_q == LAST_CNT);
    assign is_addr_cycle = (state_q != S_IDLE) && (state_q != S_CPU_DATA) &&
                           (state_q != S_D_DATA);
    assign rd_pass       = (state_q == S_IDLE) && cpu_dat_rd && !sel_pend_q && !dat_pend_q;

    // A strobe arriving this clk is forwarded straight into arbitration so
    // that the bus becomes active on the very next clk.
    assign sel_v = cpu_sel_wr ? cpu_data : sel_val_q;
    assign dat_v = cpu_dat_wr ? cpu_data : dat_val_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            din_q      <= '0;
            sel_pend_q <= 1'b0;
            sel_val_q  <= '0;
            dat_pend_q <= 1'b0;
            dat_val_q  <= '0;
            cpu_chip_q <= 1'b1;
            cpu_reg_q  <= '0;
            hw_chip_q  <= 1'b1;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            din_q      <= din_d;
            sel_pend_q <= sel_pend_d;
            sel_val_q  <= sel_val_d;
            dat_pend_q <= dat_pend_d;
            dat_val_q  <= dat_val_d;
            cpu_chip_q <= cpu_chip_d;
            cpu_reg_q  <= cpu_reg_d;
            hw_chip_q  <= hw_chip_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        din_d      = din_q;
        sel_pend_d = sel_pend_q;
        sel_val_d  = sel_val_q;
        dat_pend_d = dat_pend_q;
        dat_val_d  = dat_val_q;
        cpu_chip_d = cpu_chip_q;
        cpu_reg_d  = cpu_reg_q;
        hw_chip_d  = hw_chip_q;
        overrun_d  = (cpu_sel_wr && sel_pend_q) || (cpu_dat_wr && dat_pend_q);

        // CPU capture: last write of each kind wins.
        if (cpu_sel_wr) begin
            sel_pend_d = 1'b1;
            sel_val_d  = cpu_data;
        end
        if (cpu_dat_wr) begin
            dat_pend_d = 1'b1;
            dat_val_d  = cpu_data;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (sel_pend_q || cpu_sel_wr) begin
                    state_d = S_CPU_ADDR;
                    din_d   = sel_v;
                end else if (dat_pend_q || cpu_dat_wr) begin
                    state_d = S_CPU_DATA;
                    din_d   = dat_v;
                end else if (dma_req) begin
                    if (hw_chip_q == dma_chip) begin
                        state_d = S_D_REG;
                        din_d   = {4'h0, dma_reg};
                    end else begin
                        state_d = S_D_CHIP;
                        din_d   = {CHIP_SEL, dma_chip};
                    end
                end
            end
            default: begin
                if (!cycle_end) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    cnt_d = '0;
                    // Track which chip the hardware currently has selected.
                    if (is_addr_cycle && (din_q[7:1] == CHIP_SEL)) begin
                        hw_chip_d = din_q[0];
                    end
                    case (state_q)
                        S_CPU_ADDR: begin
                            // A fresh strobe in this clk keeps the request alive.
                            sel_pend_d = cpu_sel_wr;
                            if (din_q[7:1] == CHIP_SEL) begin
                                cpu_chip_d = din_q[0];
                            end else begin
                                cpu_reg_d = din_q;
                            end
                            state_d = S_IDLE;
                        end
                        S_CPU_DATA: begin
                            dat_pend_d = cpu_dat_wr;
                            state_d    = S_IDLE;
                        end
                        S_D_CHIP: begin
                            state_d = S_D_REG;
                            din_d   = {4'h0, dma_reg};
                        end
                        S_D_REG: begin
                            state_d = S_D_DATA;
                            din_d   = dma_data;
                        end
                        S_D_DATA: begin
                            if (hw_chip_q == cpu_chip_q) begin
                                state_d = S_R_REG;
                                din_d   = cpu_reg_q;
                            end else begin
                                state_d = S_R_CHIP;
                                din_d   = {CHIP_SEL, cpu_chip_q};
                            end
                        end
                        S_R_CHIP: begin
                            state_d = S_R_REG;
                            din_d   = cpu_reg_q;
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

    // Bus control decoded from registered state, so reset clears it at once.
    always_comb begin
        bdir = 1'b0;
        bc1  = 1'b0;
        if (state_q == S_IDLE) begin
            bc1 = rd_pass;
        end else if (cnt_q < LAST_CNT) begin
            bdir = 1'b1;
            bc1  = is_addr_cycle;
        end
    end

    assign psg_din     = rd_pass ? cpu_reg_q : din_q;
    assign busy        = (state_q != S_IDLE);
    assign cpu_wait    = cpu_dat_rd && ((state_q != S_IDLE) || sel_pend_q || dat_pend_q);
    assign cpu_overrun = overrun_q;
    assign dma_ack     = (state_q == S_D_DATA) && cycle_end;

endmodule

// File: tb/tb_psg_bus_sequencer.sv
module tb_psg_bus_sequencer;

    typedef struct packed {
        logic [1:0] code;
        logic [7:0] din;
    } cyc_t;

    logic       clk;
    logic       reset_n;
    logic       cpu_sel_wr;
    logic       cpu_dat_wr;
    logic       cpu_dat_rd;
    logic [7:0] cpu_data;
    logic       cpu_wait;
    logic       cpu_overrun;
    logic       dma_req;
    logic       dma_chip;
    logic [3:0] dma_reg;
    logic [7:0] dma_data;
    logic       dma_ack;
    logic       bdir;
    logic       bc1;
    logic [7:0] psg_din;
    logic       busy;

    psg_bus_sequencer #(.STROBE_CYCLES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_sel_wr  (cpu_sel_wr),
        .cpu_dat_wr  (cpu_dat_wr),
        .cpu_dat_rd  (cpu_dat_rd),
        .cpu_data    (cpu_data),
        .cpu_wait    (cpu_wait),
        .cpu_overrun (cpu_overrun),
        .dma_req     (dma_req),
        .dma_chip    (dma_chip),
        .dma_reg     (dma_reg),
        .dma_data    (dma_data),
        .dma_ack     (dma_ack),
        .bdir        (bdir),
        .bc1         (bc1),
        .psg_din     (psg_din),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   ack_cnt  = 0;
    int   ovr_cnt  = 0;
    int   run_len  = 0;
    logic run_bad  = 1'b0;
    cyc_t run_cyc;
    cyc_t mon_e;
    cyc_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic exp_cyc(input logic [1:0] code, input logic [7:0] din);
        cyc_t c;
        c.code = code;
        c.din  = din;
        exp_q.push_back(c);
    endtask

    // Monitor: each completed bus cycle is checked against the scoreboard.
    always @(negedge clk) begin
        if (!reset_n) begin
            run_len = 0;
            run_bad = 1'b0;
        end else if (bdir) begin
            if (run_len == 0) begin
                run_cyc.code = {bdir, bc1};
                run_cyc.din  = psg_din;
            end else if (({bdir, bc1} != run_cyc.code) || (psg_din != run_cyc.din)) begin
                run_bad = 1'b1;
            end
            run_len++;
        end else if (run_len != 0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL bus_cycle: got code=%b din=0x%h, expected no cycle",
                         run_cyc.code, run_cyc.din);
            end else begin
                mon_e = exp_q.pop_front();
                if ((run_cyc.code !== mon_e.code) || (run_cyc.din !== mon_e.din) ||
                    (run_len != 2) || run_bad || (psg_din !== run_cyc.din) || bc1) begin
                    n_fail++;
                    $display("FAIL bus_cycle: got code=%b din=0x%h len=%0d idle_din=0x%h unstable=%0b, expected code=%b din=0x%h len=2",
                             run_cyc.code, run_cyc.din, run_len, psg_din, run_bad,
                             mon_e.code, mon_e.din);
                end else begin
                    $display("bus cycle code=%b din=0x%h len=%0d", run_cyc.code, run_cyc.din, run_len);
                end
            end
            run_len = 0;
            run_bad = 1'b0;
        end
        if (reset_n && dma_ack) ack_cnt++;
        if (reset_n && cpu_overrun) ovr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sel(input logic [7:0] d);
        tick();
        cpu_data   = d;
        cpu_sel_wr = 1'b1;
        tick();
        cpu_sel_wr = 1'b0;
    endtask

    task automatic pulse_dat(input logic [7:0] d);
        tick();
        cpu_data   = d;
        cpu_dat_wr = 1'b1;
        tick();
        cpu_dat_wr = 1'b0;
    endtask

    task automatic dma_op(input logic chip, input logic [3:0] rg, input logic [7:0] d);
        logic got;
        got = 1'b0;
        tick();
        dma_chip = chip;
        dma_reg  = rg;
        dma_data = d;
        dma_req  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dma_ack) begin
                got = 1'b1;
                break;
            end
        end
        chk("dma_ack_seen", 32'(got), 32'd1);
        tick();
        dma_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int quiet;
        quiet = 0;
        for (int i = 0; i < 400 && quiet < 3; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) quiet++;
            else quiet = 0;
        end
        chk(name, 32'(quiet >= 3), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks0;
        int ovr0;
        logic found;
        reset_n    = 1'b0;
        cpu_sel_wr = 1'b0;
        cpu_dat_wr = 1'b0;
        cpu_dat_rd = 1'b0;
        cpu_data   = '0;
        dma_req    = 1'b0;
        dma_chip   = 1'b0;
        dma_reg    = '0;
        dma_data   = '0;

        // Reset state
        #2;
        chk("rst_bdir", 32'(bdir), 32'd0);
        chk("rst_bc1", 32'(bc1), 32'd0);
        chk("rst_psg_din", 32'(psg_din), 32'd0);
        chk("rst_cpu_wait", 32'(cpu_wait), 32'd0);
        chk("rst_dma_ack", 32'(dma_ack), 32'd0);
        chk("rst_overrun", 32'(cpu_overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;

        // 1: CPU select 0x07 then data 0x38; read shows cpu_reg = 7
        exp_cyc(2'b11, 8'h07);
        exp_cyc(2'b10, 8'h38);
        pulse_sel(8'h07);
        pulse_dat(8'h38);
        wait_idle("t1_idle");
        tick();
        cpu_dat_rd = 1'b1;
        @(negedge clk);
        chk("t1_rd_ctrl", 32'({bdir, bc1}), 32'b01);
        chk("t1_rd_din_cpu_reg", 32'(psg_din), 32'h07);
        chk("t1_rd_wait", 32'(cpu_wait), 32'd0);
        tick();
        cpu_dat_rd = 1'b0;
        chk("t1_no_overrun", 32'(ovr_cnt), 32'd0);

        // 2: select second chip, DMA to first chip: full 5-cycle op with restore
        exp_cyc(2'b11, 8'hFE);
        exp_cyc(2'b11, 8'hFF);
        exp_cyc(2'b11, 8'h08);
        exp_cyc(2'b10, 8'h0F);
        exp_cyc(2'b11, 8'hFE);
        exp_cyc(2'b11, 8'h07);
        pulse_sel(8'hFE);
        dma_op(1'b1, 4'd8, 8'h0F);
        wait_idle("t2_idle");

        // 3: back to first chip; DMA to matching chip skips chip cycles
        exp_cyc(2'b11, 8'hFF);
        exp_cyc(2'b11, 8'h03);
        exp_cyc(2'b10, 8'hAA);
        exp_cyc(2'b11, 8'h07);
        pulse_sel(8'hFF);
        dma_op(1'b1, 4'd3, 8'hAA);
        wait_idle("t3_idle");

        // 4: CPU read during DMA stalls, then passes through once idle
        exp_cyc(2'b11, 8'h05);
        exp_cyc(2'b10, 8'h55);
        exp_cyc(2'b11, 8'h07);
        fork
            dma_op(1'b1, 4'd5, 8'h55);
            begin
                tick();
                tick();
                cpu_dat_rd = 1'b1;
                @(negedge clk);
                chk("t4_wait_busy", 32'(cpu_wait), 32'd1);
                found = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (!busy) begin
                        found = 1'b1;
                        break;
                    end
                end
                chk("t4_became_idle", 32'(found), 32'd1);
                chk("t4_wait_idle", 32'(cpu_wait), 32'd0);
                chk("t4_rd_ctrl", 32'({bdir, bc1}), 32'b01);
                chk("t4_rd_din", 32'(psg_din), 32'h07);
                tick();
                cpu_dat_rd = 1'b0;
            end
        join
        wait_idle("t4_idle");

        // 5: two CPU data writes during DMA -> one overrun, single write after restore
        ovr0 = ovr_cnt;
        exp_cyc(2'b11, 8'hFE);
        exp_cyc(2'b11, 8'h01);
        exp_cyc(2'b10, 8'h99);
        exp_cyc(2'b11, 8'hFF);
        exp_cyc(2'b11, 8'h07);
        exp_cyc(2'b10, 8'h22);
        fork
            dma_op(1'b0, 4'd1, 8'h99);
            begin
                repeat (3) tick();
                pulse_dat(8'h11);
                pulse_dat(8'h22);
            end
        join
        wait_idle("t5_idle");
        chk("t5_overrun_pulses", 32'(ovr_cnt - ovr0), 32'd1);

        // 6: reset during D_DATA aborts at once, no ack; shadows return to reset values
        acks0 = ack_cnt;
        exp_cyc(2'b11, 8'h02);
        tick();
        dma_chip = 1'b1;
        dma_reg  = 4'd2;
        dma_data = 8'h33;
        dma_req  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bdir && !bc1) begin
                found = 1'b1;
                break;
            end
        end
        chk("t6_reached_d_data", 32'(found), 32'd1);
        reset_n = 1'b0;
        dma_req = 1'b0;
        #1;
        chk("t6_rst_ctrl", 32'({bdir, bc1}), 32'b00);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("t6_no_ack", 32'(ack_cnt - acks0), 32'd0);
        reset_n = 1'b1;
        exp_cyc(2'b11, 8'h04);
        exp_cyc(2'b10, 8'h44);
        exp_cyc(2'b11, 8'h00);
        dma_op(1'b1, 4'd4, 8'h44);
        wait_idle("t6_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
